// File: rtl/dispense_pkg.sv
// Shared definitions for the candy dispenser motion sequencer: mode codes,
// FSM encoding, motor pin constants and the mode decoder.
package dispense_pkg;

    localparam logic [2:0] MODE_NOP_LO        = 3'b000;
    localparam logic [2:0] MODE_STEP_FWD_SLOW = 3'b001;
    localparam logic [2:0] MODE_STEP_REV_SLOW = 3'b010;
    localparam logic [2:0] MODE_STEP_FWD_FAST = 3'b011;
    localparam logic [2:0] MODE_DC_L_SLOW     = 3'b100;
    localparam logic [2:0] MODE_DC_R_SLOW     = 3'b101;
    localparam logic [2:0] MODE_DC_L_FAST     = 3'b110;
    localparam logic [2:0] MODE_NOP_HI        = 3'b111;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] STEP_RUN = 2'd1;
    localparam logic [1:0] DC_RUN   = 2'd2;
    localparam logic [1:0] ACK      = 2'd3;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // H-bridge pin pairs, packed as {in1, in2}
    localparam logic [1:0] DC_OFF   = 2'b00;
    localparam logic [1:0] DC_LEFT  = 2'b01;
    localparam logic [1:0] DC_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        MOTOR_NONE = 2'd0,
        MOTOR_STEP = 2'd1,
        MOTOR_DC   = 2'd2
    } motor_e;

    typedef struct packed {
        motor_e     motor;
        logic       dir;
        logic       fast;
        logic [1:0] dc_pins;
    } mode_dec_t;

    function automatic mode_dec_t decode_mode(input logic [2:0] mode);
        mode_dec_t d;
        d.motor   = MOTOR_NONE;
        d.dir     = DIR_FWD;
        d.fast    = 1'b0;
        d.dc_pins = DC_OFF;
        case (mode)
            MODE_STEP_FWD_SLOW: d.motor = MOTOR_STEP;
            MODE_STEP_REV_SLOW: begin
                d.motor = MOTOR_STEP;
                d.dir   = DIR_REV;
            end
            MODE_STEP_FWD_FAST: begin
                d.motor = MOTOR_STEP;
                d.fast  = 1'b1;
            end
            MODE_DC_L_SLOW: begin
                d.motor   = MOTOR_DC;
                d.dc_pins = DC_LEFT;
            end
            MODE_DC_R_SLOW: begin
                d.motor   = MOTOR_DC;
                d.dc_pins = DC_RIGHT;
            end
            MODE_DC_L_FAST: begin
                d.motor   = MOTOR_DC;
                d.dc_pins = DC_LEFT;
                d.fast    = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

    // Smallest width (at least 1) able to hold max_val.
    function automatic int count_width(input longint max_val);
        int w;
        w = 1;
        while ((longint'(1) << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dispense_sequencer_rate_divider.sv
// Reloadable step-rate divider: while enabled, emits a one-cycle tick every
// N cycles, the first one N cycles after the load.
module rate_divider #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + WIDTH'(1);
        end
    end

    assign tick = en && !load && (cnt_reg == LAST);

endmodule

// File: rtl/dispense_sequencer.sv
// Candy dispenser motion sequencer: accepts a (mode, amount) command from the
// Pi over a 4-phase req/ack handshake and runs the stepper or the DC motor.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int DIV_W          = 16,
    parameter int STEP_DIV_SLOW  = 6400,
    parameter int STEP_DIV_FAST  = 2000,
    parameter int STEPS_PER_UNIT = 200,
    parameter int AMT_W          = 2,
    parameter int PWM_W          = 8,
    parameter int DUTY_SLOW      = 64,
    parameter int DUTY_FAST      = 192,
    parameter int DC_RUN_CYC     = 208000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_req_i,
    input  logic [2:0]       cmd_mode_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    output logic             step_o,
    output logic             dir_o,
    output logic             dc_in1_o,
    output logic             dc_in2_o,
    output logic             dc_pwm_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic             aborted_o
);

    localparam longint AMT_MAX   = (longint'(1) << AMT_W) - 1;
    localparam int STEP_CNT_W    = count_width(AMT_MAX * longint'(STEPS_PER_UNIT));
    localparam int DC_CNT_W      = count_width(AMT_MAX * longint'(DC_RUN_CYC));
    localparam int DUTY_W        = PWM_W + 1;

    localparam logic [STEP_CNT_W-1:0] STEPS_PER_UNIT_V = STEP_CNT_W'(STEPS_PER_UNIT);
    localparam logic [DC_CNT_W-1:0]   DC_RUN_CYC_V     = DC_CNT_W'(DC_RUN_CYC);
    localparam logic [DUTY_W-1:0]     DUTY_SLOW_V      = DUTY_W'(DUTY_SLOW);
    localparam logic [DUTY_W-1:0]     DUTY_FAST_V      = DUTY_W'(DUTY_FAST);

    logic                  req_meta_reg;
    logic                  req_s_reg;

    logic [1:0]            state_reg,       state_next;
    logic                  step_reg,        step_next;
    logic                  dir_reg,         dir_next;
    logic                  in1_reg,         in1_next;
    logic                  in2_reg,         in2_next;
    logic                  pwm_reg,         pwm_next;
    logic                  ack_reg,         ack_next;
    logic                  busy_reg,        busy_next;
    logic                  aborted_reg,     aborted_next;
    logic                  fast_reg,        fast_next;
    logic [DUTY_W-1:0]     duty_reg,        duty_next;
    logic [STEP_CNT_W-1:0] step_target_reg, step_target_next;
    logic [STEP_CNT_W-1:0] rise_cnt_reg,    rise_cnt_next;
    logic [DC_CNT_W-1:0]   dc_last_reg,     dc_last_next;
    logic [DC_CNT_W-1:0]   run_cnt_reg,     run_cnt_next;
    logic [PWM_W-1:0]      pwm_cnt_reg,     pwm_cnt_next;

    mode_dec_t             dec;
    logic                  div_load;
    logic                  step_en;
    logic [1:0]            div_tick;
    logic                  step_tick;

    assign dec     = decode_mode(cmd_mode_i);
    assign step_en = (state_reg == STEP_RUN);

    // Index 0 paces the slow step modes, index 1 the fast one.
    for (genvar gi = 0; gi < 2; gi++) begin : g_div
        localparam int DIV_N = (gi == 0) ? STEP_DIV_SLOW : STEP_DIV_FAST;
        rate_divider #(
            .N     (DIV_N),
            .WIDTH (DIV_W)
        ) u_div (
            .clk  (clk),
            .rst  (rst),
            .load (div_load),
            .en   (step_en),
            .tick (div_tick[gi])
        );
    end

    assign step_tick = fast_reg ? div_tick[1] : div_tick[0];

    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        dir_next         = dir_reg;
        in1_next         = in1_reg;
        in2_next         = in2_reg;
        pwm_next         = pwm_reg;
        ack_next         = ack_reg;
        busy_next        = busy_reg;
        aborted_next     = aborted_reg;
        fast_next        = fast_reg;
        duty_next        = duty_reg;
        step_target_next = step_target_reg;
        rise_cnt_next    = rise_cnt_reg;
        dc_last_next     = dc_last_reg;
        run_cnt_next     = run_cnt_reg;
        pwm_cnt_next     = pwm_cnt_reg;
        div_load         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_s_reg) begin
                    div_load         = 1'b1;
                    busy_next        = 1'b1;
                    aborted_next     = 1'b0;
                    fast_next        = dec.fast;
                    duty_next        = dec.fast ? DUTY_FAST_V : DUTY_SLOW_V;
                    step_target_next = STEP_CNT_W'(cmd_amt_i) * STEPS_PER_UNIT_V;
                    dc_last_next     = DC_CNT_W'(cmd_amt_i) * DC_RUN_CYC_V - DC_CNT_W'(1);
                    rise_cnt_next    = '0;
                    run_cnt_next     = '0;
                    pwm_cnt_next     = '0;
                    if (cmd_amt_i == '0 || dec.motor == MOTOR_NONE) begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end else if (dec.motor == MOTOR_STEP) begin
                        state_next = STEP_RUN;
                        dir_next   = dec.dir;
                    end else begin
                        state_next             = DC_RUN;
                        {in1_next, in2_next}   = dec.dc_pins;
                        pwm_next               = (duty_next != '0);
                    end
                end
            end

            STEP_RUN: begin
                if (!req_s_reg) begin
                    state_next   = IDLE;
                    step_next    = 1'b0;
                    dir_next     = 1'b0;
                    busy_next    = 1'b0;
                    aborted_next = 1'b1;
                end else if (step_tick) begin
                    if (!step_reg) begin
                        step_next     = 1'b1;
                        rise_cnt_next = rise_cnt_reg + STEP_CNT_W'(1);
                    end else begin
                        // The run ends on the fall that follows the last counted rise.
                        step_next = 1'b0;
                        if (rise_cnt_reg == step_target_reg) begin
                            state_next = ACK;
                            ack_next   = 1'b1;
                            dir_next   = 1'b0;
                        end
                    end
                end
            end

            DC_RUN: begin
                if (!req_s_reg) begin
                    state_next   = IDLE;
                    in1_next     = 1'b0;
                    in2_next     = 1'b0;
                    pwm_next     = 1'b0;
                    busy_next    = 1'b0;
                    aborted_next = 1'b1;
                end else if (run_cnt_reg == dc_last_reg) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                    in1_next   = 1'b0;
                    in2_next   = 1'b0;
                    pwm_next   = 1'b0;
                end else begin
                    run_cnt_next = run_cnt_reg + DC_CNT_W'(1);
                    pwm_cnt_next = pwm_cnt_reg + PWM_W'(1);
                    pwm_next     = ({1'b0, pwm_cnt_next} < duty_reg);
                end
            end

            ACK: begin
                if (!req_s_reg) begin
                    state_next = IDLE;
                    ack_next   = 1'b0;
                    busy_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_meta_reg    <= 1'b0;
            req_s_reg       <= 1'b0;
            state_reg       <= IDLE;
            step_reg        <= 1'b0;
            dir_reg         <= 1'b0;
            in1_reg         <= 1'b0;
            in2_reg         <= 1'b0;
            pwm_reg         <= 1'b0;
            ack_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            aborted_reg     <= 1'b0;
            fast_reg        <= 1'b0;
            duty_reg        <= '0;
            step_target_reg <= '0;
            rise_cnt_reg    <= '0;
            dc_last_reg     <= '0;
            run_cnt_reg     <= '0;
            pwm_cnt_reg     <= '0;
        end else begin
            req_meta_reg    <= cmd_req_i;
            req_s_reg       <= req_meta_reg;
            state_reg       <= state_next;
            step_reg        <= step_next;
            dir_reg         <= dir_next;
            in1_reg         <= in1_next;
            in2_reg         <= in2_next;
            pwm_reg         <= pwm_next;
            ack_reg         <= ack_next;
            busy_reg        <= busy_next;
            aborted_reg     <= aborted_next;
            fast_reg        <= fast_next;
            duty_reg        <= duty_next;
            step_target_reg <= step_target_next;
            rise_cnt_reg    <= rise_cnt_next;
            dc_last_reg     <= dc_last_next;
            run_cnt_reg     <= run_cnt_next;
            pwm_cnt_reg     <= pwm_cnt_next;
        end
    end

    assign step_o    = step_reg;
    assign dir_o     = dir_reg;
    assign dc_in1_o  = in1_reg;
    assign dc_in2_o  = in2_reg;
    assign dc_pwm_o  = pwm_reg;
    assign ack_o     = ack_reg;
    assign busy_o    = busy_reg;
    assign aborted_o = aborted_reg;

endmodule
